// File: rtl/dca_lsu_store_arbiter.sv
// Round-robin arbiter sharing one LSU store path (txn + wdata channels) between NUM_REQ requesters.
// Granted IDs are queued in an order FIFO so wdata beats reach the LSU in transaction order.
module dca_lsu_store_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int BW_TXN_INFO   = 32,
  parameter int BW_WDATA_INFO = 64,
  parameter int ORDER_DEPTH   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_txn_valid,
  input  logic [NUM_REQ*BW_TXN_INFO-1:0]   req_txn_info,
  output logic [NUM_REQ-1:0]               req_txn_ready,
  input  logic [NUM_REQ-1:0]               req_wdata_valid,
  input  logic [NUM_REQ*BW_WDATA_INFO-1:0] req_wdata_info,
  input  logic [NUM_REQ-1:0]               req_wdata_last,
  output logic [NUM_REQ-1:0]               req_wdata_ready,
  output logic                             lsu_txn_valid,
  output logic [BW_TXN_INFO-1:0]           lsu_txn_info,
  input  logic                             lsu_txn_ready,
  output logic                             lsu_wdata_valid,
  output logic [BW_WDATA_INFO-1:0]         lsu_wdata_info,
  output logic                             lsu_wdata_last,
  input  logic                             lsu_wdata_ready,
  output logic                             busy
);

  localparam int BW_ID  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW_CNT = $clog2(ORDER_DEPTH + 1);
  localparam int BW_PTR = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e             state_q, state_d;
  logic [BW_ID-1:0]   grantId_q, grantId_d;
  logic [BW_ID-1:0]   rrPtr_q, rrPtr_d;
  logic [BW_CNT-1:0]  count_q, count_d;
  logic [BW_PTR-1:0]  rdPtr_q, rdPtr_d;
  logic [BW_PTR-1:0]  wrPtr_q, wrPtr_d;
  logic [BW_ID-1:0]   orderFifo_q [ORDER_DEPTH];

  logic [BW_TXN_INFO-1:0]   txnInfoArr   [NUM_REQ];
  logic [BW_WDATA_INFO-1:0] wdataInfoArr [NUM_REQ];

  logic [BW_ID-1:0] winner;
  logic [BW_ID-1:0] cand;
  logic [BW_ID-1:0] head;
  logic             found;
  logic             push;
  logic             pop;
  logic             fifoEmpty;
  logic             fifoFull;

  for (genvar g = 0; g < NUM_REQ; g++) begin : gUnpack
    assign txnInfoArr[g]   = req_txn_info[g*BW_TXN_INFO +: BW_TXN_INFO];
    assign wdataInfoArr[g] = req_wdata_info[g*BW_WDATA_INFO +: BW_WDATA_INFO];
  end

  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == BW_CNT'(ORDER_DEPTH));
  assign head      = orderFifo_q[rdPtr_q];
  assign busy      = (state_q != IDLE) || !fifoEmpty;

  // First valid requester at or after rrPtr_q, scanning modulo NUM_REQ.
  always_comb begin
    winner = rrPtr_q;
    cand   = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = BW_ID'((int'(rrPtr_q) + k) % NUM_REQ);
      if (!found && req_txn_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grantId_d = grantId_q;
    rrPtr_d   = rrPtr_q;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && !fifoFull) begin
          grantId_d = winner;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (lsu_txn_ready) begin
          push    = 1'b1;
          state_d = IDLE;
          rrPtr_d = (int'(grantId_q) == NUM_REQ - 1) ? '0 : grantId_q + BW_ID'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The grant stays locked while in ISSUE; info is passed straight through from the requester.
  always_comb begin
    req_txn_ready = '0;
    lsu_txn_valid = (state_q == ISSUE);
    lsu_txn_info  = txnInfoArr[grantId_q];
    if (state_q == ISSUE) begin
      req_txn_ready[grantId_q] = lsu_txn_ready;
    end
  end

  always_comb begin
    req_wdata_ready = '0;
    lsu_wdata_valid = !fifoEmpty && req_wdata_valid[head];
    lsu_wdata_info  = wdataInfoArr[head];
    lsu_wdata_last  = req_wdata_last[head];
    if (!fifoEmpty) begin
      req_wdata_ready[head] = lsu_wdata_ready;
    end
  end

  assign pop = lsu_wdata_valid && lsu_wdata_ready && lsu_wdata_last;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = (int'(wrPtr_q) == ORDER_DEPTH - 1) ? '0 : wrPtr_q + BW_PTR'(1);
    end
    if (pop) begin
      rdPtr_d = (int'(rdPtr_q) == ORDER_DEPTH - 1) ? '0 : rdPtr_q + BW_PTR'(1);
    end
    if (push && !pop) begin
      count_d = count_q + BW_CNT'(1);
    end else if (pop && !push) begin
      count_d = count_q - BW_CNT'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grantId_q <= '0;
      rrPtr_q   <= '0;
      count_q   <= '0;
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
    end else begin
      state_q   <= state_d;
      grantId_q <= grantId_d;
      rrPtr_q   <= rrPtr_d;
      count_q   <= count_d;
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
    end
  end

  // FIFO storage needs no reset: entries are only read while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      orderFifo_q[wrPtr_q] <= grantId_q;
    end
  end

endmodule
